// File: rtl/text_console_writer_if.sv
// Console writer bus bundle.
//   CPU side : char_data / char_valid / char_ready handshake, clear_screen pulse.
//   RAM side : ram_address, ram_data_out, ram_write_enable (to text RAM port A),
//              ram_data_in (port A read data, one cycle after the address).
//   Status   : cursor_row, cursor_col.
// The slave modport is the writer engine; master is the CPU/RAM environment.
interface text_console_writer_if #(
  parameter int COLUMNS    = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS)
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLUMNS);

  logic [6:0]            char_data;
  logic                  char_valid;
  logic                  char_ready;
  logic                  clear_screen;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [6:0]            ram_data_out;
  logic                  ram_write_enable;
  logic [6:0]            ram_data_in;
  logic [ROW_W-1:0]      cursor_row;
  logic [COL_W-1:0]      cursor_col;

  modport master (
    output char_data, char_valid, clear_screen, ram_data_in,
    input  char_ready, ram_address, ram_data_out, ram_write_enable,
           cursor_row, cursor_col
  );

  modport slave (
    input  char_data, char_valid, clear_screen, ram_data_in,
    output char_ready, ram_address, ram_data_out, ram_write_enable,
           cursor_row, cursor_col
  );
endinterface

// File: rtl/text_console_writer.sv
// Writer-side engine for the GPU text buffer.
// Accepts 7-bit ASCII over a valid/ready handshake, writes glyph codes into the
// text RAM (port A), tracks the cursor, handles LF / CR / BS, scrolls the
// screen up one row on overflow of the last row, and blanks the whole screen
// on a clear_screen request.
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - text_console_writer_if.slave (CPU handshake, RAM port A, cursor)
// All outputs are registered.
module text_console_writer #(
  parameter int COLUMNS    = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  text_console_writer_if.slave bus
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLUMNS);
  localparam int TOTAL = COLUMNS*ROWS;
  // Read pointer runs one past the last address, so it needs an extra bit.
  localparam int PTR_W = ADDR_WIDTH + 1;

  localparam logic [PTR_W-1:0]      TOTAL_P       = PTR_W'(TOTAL);
  localparam logic [PTR_W-1:0]      SECOND_SRC    = PTR_W'(COLUMNS + 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A        = ADDR_WIDTH'(COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'(TOTAL - COLUMNS);
  localparam logic [ROW_W-1:0]      LAST_ROW      = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]      LAST_COL      = COL_W'(COLUMNS - 1);

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_BS    = 7'h08;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL_READ,
    SCROLL_WRITE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [6:0]            char_q, char_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [6:0]            hold_q, hold_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [6:0]            wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] cursor_addr;
  logic [6:0]            rdata;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  assign cursor_addr = ADDR_WIDTH'(row_q) * COLS_A + ADDR_WIDTH'(col_q);

  // Scroll pipeline: the port carries R0 R1 W0 R2 W1 ... R(n-1) W(n-2) W(n-1).
  // Read data arrives one slot after its read, so whenever the previous slot
  // was a read the fresh RAM data is used and also parked in hold_q for the
  // write that follows the next read.
  assign rdata = rd_valid_q ? bus.ram_data_in : hold_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    char_d     = char_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    hold_d     = rdata;
    rd_valid_d = (state_q == SCROLL_READ);
    ready_d    = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.clear_screen) begin
          // Clear has priority; a simultaneous character stays pending.
          ready_d = 1'b0;
          state_d = CLEAR_ALL;
          row_d   = '0;
          col_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = CH_SPACE;
        end else if (bus.char_valid && ready_q) begin
          ready_d = 1'b0;
          char_d  = bus.char_data;
          if (bus.char_data == CH_LF && row_q == LAST_ROW) begin
            // Newline on the last row goes straight into the scroll.
            state_d  = SCROLL_READ;
            row_d    = LAST_ROW;
            col_d    = '0;
            addr_d   = COLS_A;
            rd_ptr_d = SECOND_SRC;
            wr_ptr_d = '0;
          end else begin
            state_d = WRITE;
            if (is_printable(bus.char_data)) begin
              we_d    = 1'b1;
              addr_d  = cursor_addr;
              wdata_d = bus.char_data;
            end else if (bus.char_data == CH_BS && col_q != '0) begin
              we_d    = 1'b1;
              addr_d  = cursor_addr - ADDR_WIDTH'(1);
              wdata_d = CH_SPACE;
            end
          end
        end
      end

      WRITE: begin
        // The RAM write (if any) is on the port this cycle; move the cursor.
        state_d = IDLE;
        ready_d = 1'b1;
        if (is_printable(char_q)) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              ready_d  = 1'b0;
              state_d  = SCROLL_READ;
              addr_d   = COLS_A;
              rd_ptr_d = SECOND_SRC;
              wr_ptr_d = '0;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else if (char_q == CH_LF) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            ready_d  = 1'b0;
            state_d  = SCROLL_READ;
            addr_d   = COLS_A;
            rd_ptr_d = SECOND_SRC;
            wr_ptr_d = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else if (char_q == CH_CR) begin
          col_d = '0;
        end else if (char_q == CH_BS && col_q != '0) begin
          col_d = col_q - COL_W'(1);
        end
      end

      SCROLL_READ: begin
        if (rd_ptr_q == SECOND_SRC) begin
          // Second read is issued back-to-back to prime the pipeline.
          addr_d   = rd_ptr_q[ADDR_WIDTH-1:0];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
          state_d  = SCROLL_WRITE;
          we_d     = 1'b1;
          addr_d   = wr_ptr_q;
          wdata_d  = rdata;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
      end

      SCROLL_WRITE: begin
        if (wr_ptr_q == LAST_ROW_BASE) begin
          state_d = CLEAR_ROW;
          we_d    = 1'b1;
          addr_d  = LAST_ROW_BASE;
          wdata_d = CH_SPACE;
        end else if (rd_ptr_q == TOTAL_P) begin
          // All sources read: the final copy follows immediately.
          we_d     = 1'b1;
          addr_d   = wr_ptr_q;
          wdata_d  = rdata;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
          state_d  = SCROLL_READ;
          addr_d   = rd_ptr_q[ADDR_WIDTH-1:0];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end

      CLEAR_ROW, CLEAR_ALL: begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wdata_d = CH_SPACE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      char_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      hold_q     <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      char_q     <= char_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      hold_q     <= hold_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.char_ready       = ready_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_address      = addr_q;
  assign bus.ram_data_out     = wdata_q;
  assign bus.cursor_row       = row_q;
  assign bus.cursor_col       = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (80x30 screen).
// Models the text RAM as a synchronous read-first memory and logs every write.
module tb_text_console_writer;

  localparam int COLUMNS = 80;
  localparam int ROWS    = 30;
  localparam int TOTAL   = COLUMNS*ROWS;

  logic clock;
  logic reset_n;
  logic preload;
  logic [6:0] mem [0:TOTAL-1];
  logic [6:0] ram_rdata;

  int checks;
  int fails;

  int          log_addr [$];
  logic [6:0]  log_data [$];

  text_console_writer_if #(.COLUMNS(COLUMNS), .ROWS(ROWS)) bus ();

  text_console_writer #(.COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [6:0] pat(input int a);
    return 7'(((a*7 + 3) % 95) + 32);
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.ram_data_in = ram_rdata;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < TOTAL; i++) mem[i] <= pat(i);
    end else if (bus.ram_write_enable) begin
      mem[bus.ram_address] <= bus.ram_data_out;
    end
    ram_rdata <= mem[bus.ram_address];
    if (bus.ram_write_enable) begin
      log_addr.push_back(int'(bus.ram_address));
      log_data.push_back(bus.ram_data_out);
    end
  end

  task automatic log_clear();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (!bus.char_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!bus.char_ready) begin
      fails++;
      $display("FAIL wait_idle: char_ready got %0b required 1 within 20000 cycles", bus.char_ready);
    end
  endtask

  // Returns with the handshake edge just past (at the following negedge).
  task automatic send_char(input logic [6:0] c);
    int n = 0;
    @(negedge clock);
    while (!bus.char_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!bus.char_ready) begin
      fails++;
      $display("FAIL send_char: char_ready got 0 required 1 (char 0x%02h)", c);
    end
    bus.char_data  = c;
    bus.char_valid = 1'b1;
    @(negedge clock);
    bus.char_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!bus.char_ready && n < 20000) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    checks++;
    if (int'(bus.cursor_row) !== row || int'(bus.cursor_col) !== col) begin
      fails++;
      $display("FAIL %s: cursor got %0d/%0d required %0d/%0d", name,
               bus.cursor_row, bus.cursor_col, row, col);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.char_ready !== 1'b0 || bus.ram_write_enable !== 1'b0 ||
        bus.ram_address !== '0 || bus.ram_data_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%0b we=%0b addr=%0d data=%0h required 0/0/0/0",
               bus.char_ready, bus.ram_write_enable, bus.ram_address, bus.ram_data_out);
    end
    check_cursor("reset_cursor", 0, 0);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.char_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_release: got %0b required 0", bus.char_ready);
    end
    @(negedge clock);
    checks++;
    if (bus.char_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_first_edge: got %0b required 1", bus.char_ready);
    end
  endtask

  task automatic test_single_char();
    int n;
    log_clear();
    send_char(7'h41);
    count_busy(n);
    checks++;
    if (n !== 1) begin
      fails++;
      $display("FAIL single_busy: ready low %0d cycles required 1", n);
    end
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 0 || log_data[0] !== 7'h41) begin
      fails++;
      $display("FAIL single_write: writes=%0d addr=%0d data=%0h required 1/0/41",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : -1,
               (log_data.size() > 0) ? log_data[0] : 7'h00);
    end
    check_cursor("single_cursor", 0, 1);
  endtask

  task automatic test_full_row();
    int nbad = 0;
    int first_bad = -1;
    send_char(7'h0D);
    wait_idle();
    check_cursor("cr_cursor", 0, 0);
    log_clear();
    for (int i = 0; i < COLUMNS; i++) send_char(7'(8'h30 + (i % 64)));
    wait_idle();
    checks++;
    if (log_addr.size() !== COLUMNS) begin
      fails++;
      $display("FAIL row_write_count: got %0d required %0d", log_addr.size(), COLUMNS);
    end else begin
      for (int i = 0; i < COLUMNS; i++)
        if (log_addr[i] !== i || log_data[i] !== 7'(8'h30 + (i % 64))) begin
          nbad++;
          if (first_bad < 0) first_bad = i;
        end
      if (nbad !== 0) begin
        fails++;
        $display("FAIL row_write_data: %0d bad writes, first at index %0d (addr %0d data %0h)",
                 nbad, first_bad, log_addr[first_bad], log_data[first_bad]);
      end
    end
    check_cursor("row_wrap_cursor", 1, 0);
  endtask

  task automatic test_backspace();
    send_char(7'h0A);
    send_char(7'h0A);
    wait_idle();
    check_cursor("lf_cursor", 3, 0);
    log_clear();
    send_char(7'h08);
    wait_idle();
    checks++;
    if (log_addr.size() !== 0) begin
      fails++;
      $display("FAIL bs_col0_nowrite: writes got %0d required 0", log_addr.size());
    end
    check_cursor("bs_col0_cursor", 3, 0);
    send_char(7'h77); send_char(7'h78); send_char(7'h79); send_char(7'h7A);
    wait_idle();
    check_cursor("bs_pre_cursor", 3, 4);
    log_clear();
    send_char(7'h08);
    wait_idle();
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 243 || log_data[0] !== 7'h20) begin
      fails++;
      $display("FAIL bs_write: writes=%0d addr=%0d data=%0h required 1/243/20",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : -1,
               (log_data.size() > 0) ? log_data[0] : 7'h00);
    end
    check_cursor("bs_cursor", 3, 3);
  endtask

  task automatic test_scroll();
    int n;
    int nbad = 0;
    int first_bad = -1;
    send_char(7'h0D);
    for (int i = 0; i < 26; i++) send_char(7'h0A);
    for (int i = 0; i < 5; i++) send_char(7'h61);
    wait_idle();
    check_cursor("scroll_pre_cursor", 29, 5);
    @(negedge clock);
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
    log_clear();
    send_char(7'h0A);
    count_busy(n);
    checks++;
    if (n !== 4720) begin
      fails++;
      $display("FAIL scroll_busy: ready low %0d cycles required 4720", n);
    end
    checks++;
    if (log_addr.size() !== TOTAL) begin
      fails++;
      $display("FAIL scroll_write_count: got %0d required %0d", log_addr.size(), TOTAL);
    end
    for (int a = 0; a < TOTAL; a++) begin
      logic [6:0] exp;
      exp = (a < TOTAL - COLUMNS) ? pat(a + COLUMNS) : 7'h20;
      if (mem[a] !== exp) begin
        nbad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    checks++;
    if (nbad !== 0) begin
      fails++;
      $display("FAIL scroll_contents: %0d bad cells, first addr %0d got %0h required %0h",
               nbad, first_bad, mem[first_bad],
               (first_bad < TOTAL - COLUMNS) ? pat(first_bad + COLUMNS) : 7'h20);
    end
    check_cursor("scroll_cursor", 29, 0);
  endtask

  task automatic test_clear_with_char();
    int n;
    int nbad = 0;
    int first_bad = -1;
    wait_idle();
    log_clear();
    bus.clear_screen = 1'b1;
    bus.char_valid   = 1'b1;
    bus.char_data    = 7'h51;
    @(negedge clock);
    bus.clear_screen = 1'b0;
    checks++;
    if (bus.char_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_priority_ready: got %0b required 0", bus.char_ready);
    end
    check_cursor("clear_entry_cursor", 0, 0);
    count_busy(n);
    @(negedge clock);
    bus.char_valid = 1'b0;
    wait_idle();
    checks++;
    if (n !== TOTAL) begin
      fails++;
      $display("FAIL clear_busy: ready low %0d cycles required %0d", n, TOTAL);
    end
    checks++;
    if (log_addr.size() !== TOTAL + 1) begin
      fails++;
      $display("FAIL clear_write_count: got %0d required %0d", log_addr.size(), TOTAL + 1);
    end else begin
      for (int i = 0; i < TOTAL; i++)
        if (log_addr[i] !== i || log_data[i] !== 7'h20) begin
          nbad++;
          if (first_bad < 0) first_bad = i;
        end
      checks++;
      if (nbad !== 0) begin
        fails++;
        $display("FAIL clear_writes: %0d bad, first index %0d addr %0d data %0h",
                 nbad, first_bad, log_addr[first_bad], log_data[first_bad]);
      end
      checks++;
      if (log_addr[TOTAL] !== 0 || log_data[TOTAL] !== 7'h51) begin
        fails++;
        $display("FAIL clear_held_char: addr=%0d data=%0h required 0/51",
                 log_addr[TOTAL], log_data[TOTAL]);
      end
    end
    check_cursor("clear_cursor", 0, 1);
  endtask

  task automatic test_reset_mid_scroll();
    logic found = 1'b0;
    send_char(7'h0D);
    for (int i = 0; i < 29; i++) send_char(7'h0A);
    wait_idle();
    check_cursor("mid_pre_cursor", 29, 0);
    send_char(7'h0A);
    repeat (60) @(posedge clock);
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clock);
      #1;
      if (bus.ram_write_enable === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL mid_scroll_write_seen: write enable got 0 required 1 within 50 cycles");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_write_enable !== 1'b0 || bus.char_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: we=%0b ready=%0b required 0/0",
               bus.ram_write_enable, bus.char_ready);
    end
    check_cursor("mid_reset_cursor", 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.char_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: got %0b required 1", bus.char_ready);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    preload = 1'b0;
    bus.char_data    = '0;
    bus.char_valid   = 1'b0;
    bus.clear_screen = 1'b0;
    test_reset();
    test_single_char();
    test_full_row();
    test_backspace();
    test_scroll();
    test_clear_with_char();
    test_reset_mid_scroll();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer-side engine for the GPU text buffer.
- Accepts a stream of 7-bit ASCII characters over a valid/ready handshake and drives the CPU-side port of the text RAM: writes glyph codes, tracks a cursor, and interprets newline, carriage return and backspace.
- On overflow of the last row, scrolls the screen up by reading and rewriting the buffer through the same port.
- Sits between the CPU MMIO console register and the text RAM; the GPU scanout reads the other RAM port independently.

Parameters:
- COLUMNS, 80: characters per row.
- ROWS, 30: rows on screen; COLUMNS*ROWS must equal `GPU_TEXT_BUFFER_LENGTH`.
- ADDR_WIDTH, $clog2(COLUMNS*ROWS): RAM address width.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- char_data  input  7  ASCII character from CPU.
- char_valid  input  1  char_data is valid.
- char_ready  output  1  block can accept a character this cycle.
- clear_screen  input  1  single-cycle request to blank the screen and home the cursor.
- ram_address  output  ADDR_WIDTH  to RAM port A address.
- ram_data_out  output  7  to RAM port A write data.
- ram_write_enable  output  1  to RAM port A write enable.
- ram_data_in  input  7  from RAM port A read data; valid the cycle after the address is presented.
- cursor_row  output  $clog2(ROWS)  current cursor row.
- cursor_col  output  $clog2(COLUMNS)  current cursor column.

Behaviour:
- Reset (async, reset_n low):
  - state IDLE, cursor 0/0, char_ready 0.
  - ram_write_enable 0, ram_address 0, ram_data_out 0.
  - char_ready rises on the first clock edge after release. RAM contents are not touched.
- All outputs are registered.
- States: IDLE, WRITE, SCROLL_READ, SCROLL_WRITE, CLEAR_ROW, CLEAR_ALL.
- char_ready is 1 only in IDLE. Transfer occurs when char_valid and char_ready are both high at a clock edge.
- clear_screen and a handshake in the same IDLE cycle: clear wins, and the character is not consumed (ready is 0 next cycle).
- clear_screen outside IDLE is ignored.
- Character handling, with the transfer at edge N:
  - 0x20..0x7E: in cycle N+1, write the char at row*COLUMNS+col. Then col+1. If col reaches COLUMNS: col=0, row+1. Cursor updates at edge N+2.
  - 0x0A (newline): col=0, row+1; no RAM write.
  - 0x0D (carriage return): col=0; no write.
  - 0x08 (backspace): if col>0, col-1 and write 0x20 at the new position. At col=0, no-op (no reverse wrap).
  - Any other code: consumed, ignored, one cycle in WRITE with no write.
  - ready returns at edge N+2 unless a scroll starts.
- Row overflow (row would become ROWS): enter SCROLL_READ; row stays ROWS-1.
- Scroll sequence:
  - For src = COLUMNS .. COLUMNS*ROWS-1: SCROLL_READ presents src (write enable 0); the next cycle, SCROLL_WRITE writes ram_data_in to src-COLUMNS.
  - Then CLEAR_ROW writes 0x20 to the COLUMNS addresses of the last row, one per cycle.
  - Total 2*COLUMNS*(ROWS-1)+COLUMNS cycles; 4720 at defaults.
  - The cursor then sits at row ROWS-1 and the column set by the triggering character: 0 for a wrap or newline.
- CLEAR_ALL:
  - Writes 0x20 to addresses 0..COLUMNS*ROWS-1 in ascending order, one per cycle (2400 cycles at defaults).
  - Cursor resets to 0/0 on entry; returns to IDLE afterwards.
- Address arithmetic is unsigned. Address never exceeds COLUMNS*ROWS-1, and src-COLUMNS never underflows.
- Reset asserted mid-scroll or mid-clear aborts immediately; the buffer is left partially updated, which is acceptable.

Test Plan:
- Reset then send 'A' (0x41) at cursor 0/0 -> one write, address 0, data 0x41; cursor 0/1; char_ready low exactly one cycle.
- Send 80 printable chars starting at 0/0 -> writes to addresses 0..79; cursor 1/0; no scroll.
- Cursor at 29/5, send 0x0A -> scroll: reads 80..2399 and writes 0..2319 with the data read; 0x20 written to 2320..2399; cursor 29/0; char_ready low for 4720 cycles.
- Cursor 3/0, send 0x08 -> no write, cursor unchanged. Cursor 3/4, send 0x08 -> 0x20 written at address 243; cursor 3/3.
- clear_screen and char_valid together in IDLE -> 2400 writes of 0x20 to addresses 0..2399; cursor 0/0; the held character is accepted only afterwards.
- Assert reset_n low mid-scroll -> ram_write_enable 0 immediately (asynchronously); cursor 0/0; char_ready 1 one edge after release.
